// File: rtl/nd_1to2_pkg.sv
// -----------------------------------------------------------------------------
// nd_1to2_pkg
//
// Shared definitions for the 1-to-2 router node and its message FIFO:
//   - default field widths and FIFO depth for the node network
//   - message width helper (src + dst + dat + red)
//   - output stage state encoding
//
// Optional feature macro used by nd_1to2: NS_ND_1TO2_BROADCAST_EN.
// -----------------------------------------------------------------------------
package nd_1to2_pkg;

    localparam int DEF_FSZ = 4;   // per-output FIFO depth (power of 2, >= 2)
    localparam int DEF_ASZ = 6;   // src / dst width
    localparam int DEF_DSZ = 8;   // dat width
    localparam int DEF_RSZ = 2;   // red width

    // Output stage of one send channel.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } snd_state_t;

    // A message is stored and forwarded as {src, dst, dat, red}.
    function automatic int msg_width(input int asz, input int dsz, input int rsz);
        return 2 * asz + dsz + rsz;
    endfunction

endpackage

// File: rtl/nd_msg_fifo.sv
// -----------------------------------------------------------------------------
// nd_msg_fifo
//
// Message FIFO with a combinational head. Pointers are log2(FSZ)+1 bits wide
// and wrap modulo 2*FSZ: equal pointers mean empty; MSBs differing with the
// remaining bits equal means full. This pointer scheme is the same one the
// merge node uses. A push and a pop on the same edge are both honoured even
// when full, since the pop frees the slot the push writes into.
//
// Ports:
//   i_clk  in   clock, rising edge
//   reset  in   asynchronous active-low reset (clears pointers)
//   clear  in   synchronous clear of the pointers (node init cycle)
//   push   in   write wdata at the tail
//   pop    in   drop the head entry
//   wdata  in   [MW-1:0] message to write
//   head   out  [MW-1:0] oldest message (valid when !empty)
//   full   out  no free slot
//   empty  out  no stored message
// -----------------------------------------------------------------------------
module nd_msg_fifo #(
    parameter int FSZ = 4,
    parameter int MW  = 22
) (
    input  logic          i_clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [MW-1:0] wdata,
    output logic [MW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(FSZ);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [MW-1:0] mem [FSZ];
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset: contents are only observed behind the pointers.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/nd_1to2.sv
// -----------------------------------------------------------------------------
// nd_1to2
//
// Single-input, dual-output message router. Messages arriving on the rcv0
// channel are steered by dst into one of two FIFOs (dst < SPLIT_ADDR -> snd0,
// otherwise snd1); each FIFO drains into its own output channel.
//
// All channels are four-phase req/ack: the sender raises req with the fields
// stable, the receiver raises ack once it has taken the message, the sender
// drops req, and the receiver drops ack; fields only change while req and ack
// are both low.
//
// Optional feature: define NS_ND_1TO2_BROADCAST_EN to treat dst == all-ones as
// a broadcast written into both FIFOs on the same edge (acked only when both
// have space). Without it, all-ones dst is routed like any other address.
//
// Ports:
//   i_clk                     in   clock, rising edge
//   reset                     in   asynchronous active-low reset
//   ready                     out  high after the init cycle following reset
//   rcv0_src/dst/dat/red      in   input message fields
//   rcv0_req / rcv0_ack       in/out input channel handshake
//   snd0_src/dst/dat/red      out  output 0 message fields
//   snd0_req / snd0_ack       out/in output 0 handshake
//   snd1_*                    as snd0_*, for output 1
//   snd0_state / snd1_state   out  output stage state (debug)
// -----------------------------------------------------------------------------
module nd_1to2
    import nd_1to2_pkg::*;
#(
    parameter int FSZ = DEF_FSZ,
    parameter int ASZ = DEF_ASZ,
    parameter int DSZ = DEF_DSZ,
    parameter int RSZ = DEF_RSZ
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,

    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv0_req,
    output logic           rcv0_ack,

    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req,
    input  logic           snd0_ack,

    output logic [ASZ-1:0] snd1_src,
    output logic [ASZ-1:0] snd1_dst,
    output logic [DSZ-1:0] snd1_dat,
    output logic [RSZ-1:0] snd1_red,
    output logic           snd1_req,
    input  logic           snd1_ack,

    output snd_state_t     snd0_state,
    output snd_state_t     snd1_state
);

    localparam int             MW         = msg_width(ASZ, DSZ, RSZ);
    localparam logic [ASZ-1:0] SPLIT_ADDR = ASZ'(1) << (ASZ - 1);

    logic [MW-1:0]        rcv_msg;
    logic [1:0]           want;       // FIFOs this message must be written into
    logic [1:0]           can_push;   // FIFO has a slot on this edge
    logic [1:0]           push;
    logic [1:0]           snd_ack;
    logic [1:0]           snd_req;
    logic [1:0][MW-1:0]   snd_msg;
    logic                 bcast;
    logic                 new_req;
    logic                 accept;

    assign rcv_msg = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    assign snd_ack = {snd1_ack, snd0_ack};

    // ------------------------------------------------------------------
    // Routing and input acceptance
    // ------------------------------------------------------------------
`ifdef NS_ND_1TO2_BROADCAST_EN
    assign bcast = &rcv0_dst;
`else
    assign bcast = 1'b0;
`endif

    always_comb begin
        want = (rcv0_dst >= SPLIT_ADDR) ? 2'b10 : 2'b01;
        if (bcast) want = 2'b11;
    end

    // Each new request is judged on its own target(s) only, so a full FIFO
    // never blocks traffic heading to the other output.
    assign new_req = ready && rcv0_req && !rcv0_ack;
    assign accept  = new_req && ((want & ~can_push) == 2'b00);
    assign push    = accept ? want : 2'b00;

    // The first edge after reset release is the init cycle: it only raises
    // ready and re-initialises state, so no message is taken on it.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            ready    <= 1'b0;
            rcv0_ack <= 1'b0;
        end else if (!ready) begin
            ready    <= 1'b1;
            rcv0_ack <= 1'b0;
        end else if (accept) begin
            rcv0_ack <= 1'b1;
        end else if (!rcv0_req && rcv0_ack) begin
            rcv0_ack <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Per-output FIFO and output stage
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_out
        logic [MW-1:0] head;
        logic          full;
        logic          empty;
        logic          load;
        logic [MW-1:0] msg_q;
        snd_state_t    state_q;
        snd_state_t    state_d;

        nd_msg_fifo #(
            .FSZ (FSZ),
            .MW  (MW)
        ) u_fifo (
            .i_clk (i_clk),
            .reset (reset),
            .clear (!ready),
            .push  (push[g]),
            .pop   (load),
            .wdata (rcv_msg),
            .head  (head),
            .full  (full),
            .empty (empty)
        );

        // A pop in this cycle frees the slot for a push on the same edge.
        assign can_push[g] = !full || load;

        always_comb begin
            state_d = state_q;
            load    = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ready && !empty) begin
                        load    = 1'b1;
                        state_d = ST_REQ;
                    end
                end
                ST_REQ:  if (snd_ack[g])  state_d = ST_WAIT;
                ST_WAIT: if (!snd_ack[g]) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge i_clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                msg_q   <= '0;
            end else if (!ready) begin
                state_q <= ST_IDLE;
                msg_q   <= '0;
            end else begin
                state_q <= state_d;
                // Fields stay put from one load to the next.
                if (load) msg_q <= head;
            end
        end

        // req is exactly "in REQ"; it drops asynchronously with reset.
        assign snd_req[g] = (state_q == ST_REQ);
        assign snd_msg[g] = msg_q;
    end

    assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = snd_msg[0];
    assign {snd1_src, snd1_dst, snd1_dat, snd1_red} = snd_msg[1];
    assign snd0_req   = snd_req[0];
    assign snd1_req   = snd_req[1];
    assign snd0_state = g_out[0].state_q;
    assign snd1_state = g_out[1].state_q;

endmodule

// File: tb/tb_nd_1to2.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_nd_1to2
//
// Drives nd_1to2 (ASZ=6, FSZ=4) through routing, backpressure, head-of-line,
// wrap-around, randomized traffic, the all-ones destination case and a reset
// in the middle of a transfer. The reference model is a pair of expected
// message queues plus counters of messages accepted and loaded per output.
// -----------------------------------------------------------------------------
module tb_nd_1to2;
    import nd_1to2_pkg::*;

    localparam int FSZ      = 4;
    localparam int ASZ      = 6;
    localparam int DSZ      = 8;
    localparam int RSZ      = 2;
    localparam int MW       = 2 * ASZ + DSZ + RSZ;
    localparam int SPLIT    = 1 << (ASZ - 1);
    localparam int TOP_ADDR = (1 << ASZ) - 1;
`ifdef NS_ND_1TO2_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    typedef logic [MW-1:0] msg_t;

    // ---------------- DUT signals ----------------
    logic           i_clk;
    logic           reset;
    logic           ready;
    logic [ASZ-1:0] rcv0_src, rcv0_dst;
    logic [DSZ-1:0] rcv0_dat;
    logic [RSZ-1:0] rcv0_red;
    logic           rcv0_req, rcv0_ack;
    logic [ASZ-1:0] snd0_src, snd0_dst, snd1_src, snd1_dst;
    logic [DSZ-1:0] snd0_dat, snd1_dat;
    logic [RSZ-1:0] snd0_red, snd1_red;
    logic           snd0_req, snd0_ack, snd1_req, snd1_ack;
    snd_state_t     snd0_state, snd1_state;

    // ---------------- bench state ----------------
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    msg_t exp_q0[$];
    msg_t exp_q1[$];
    int   pushed0 = 0, pushed1 = 0;
    int   loaded0 = 0, loaded1 = 0;
    int   rise_cyc0 = 0, rise_cyc1 = 0;
    bit   ack_en0 = 1'b1, ack_en1 = 1'b1;
    int   max_dly = 0;

    nd_1to2 #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
        .i_clk      (i_clk),
        .reset      (reset),
        .ready      (ready),
        .rcv0_src   (rcv0_src),
        .rcv0_dst   (rcv0_dst),
        .rcv0_dat   (rcv0_dat),
        .rcv0_red   (rcv0_red),
        .rcv0_req   (rcv0_req),
        .rcv0_ack   (rcv0_ack),
        .snd0_src   (snd0_src),
        .snd0_dst   (snd0_dst),
        .snd0_dat   (snd0_dat),
        .snd0_red   (snd0_red),
        .snd0_req   (snd0_req),
        .snd0_ack   (snd0_ack),
        .snd1_src   (snd1_src),
        .snd1_dst   (snd1_dst),
        .snd1_dat   (snd1_dat),
        .snd1_red   (snd1_red),
        .snd1_req   (snd1_req),
        .snd1_ack   (snd1_ack),
        .snd0_state (snd0_state),
        .snd1_state (snd1_state)
    );

    // ---------------- clock / cycle count / watchdog ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit goes_to0(input int dst);
        return (BCAST && dst == TOP_ADDR) || (dst < SPLIT);
    endfunction

    function automatic bit goes_to1(input int dst);
        return (BCAST && dst == TOP_ADDR) || (dst >= SPLIT);
    endfunction

    task automatic model_push(input msg_t m, input int dst);
        if (goes_to0(dst)) begin exp_q0.push_back(m); pushed0++; end
        if (goes_to1(dst)) begin exp_q1.push_back(m); pushed1++; end
    endtask

    task automatic model_clear();
        exp_q0.delete();
        exp_q1.delete();
        pushed0 = 0; pushed1 = 0;
        loaded0 = 0; loaded1 = 0;
    endtask

    // ---------------- downstream peers ----------------
    initial begin
        int dly;
        dly = 0;
        snd0_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (snd0_req && !snd0_ack && ack_en0) begin
                if (dly == 0) begin
                    snd0_ack = 1'b1;
                    dly = $urandom_range(0, max_dly);
                end else dly--;
            end else if (!snd0_req && snd0_ack) begin
                snd0_ack = 1'b0;
            end
        end
    end

    initial begin
        int dly;
        dly = 0;
        snd1_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (snd1_req && !snd1_ack && ack_en1) begin
                if (dly == 0) begin
                    snd1_ack = 1'b1;
                    dly = $urandom_range(0, max_dly);
                end else dly--;
            end else if (!snd1_req && snd1_ack) begin
                snd1_ack = 1'b0;
            end
        end
    end

    // ---------------- output monitors (scoreboard) ----------------
    initial begin
        logic prev;
        msg_t cap, cur;
        prev = 1'b0;
        cap  = '0;
        forever begin
            @(negedge i_clk);
            cur = {snd0_src, snd0_dst, snd0_dat, snd0_red};
            if (snd0_req && !prev) begin
                rise_cyc0 = cyc;
                loaded0++;
                check("snd0_pending", exp_q0.size() > 0, 1);
                if (exp_q0.size() > 0) check("snd0_msg", cur, exp_q0.pop_front());
                cap = cur;
            end else if (!snd0_req && prev && reset) begin
                check("snd0_hold", cur, cap);
            end
            prev = snd0_req;
        end
    end

    initial begin
        logic prev;
        msg_t cap, cur;
        prev = 1'b0;
        cap  = '0;
        forever begin
            @(negedge i_clk);
            cur = {snd1_src, snd1_dst, snd1_dat, snd1_red};
            if (snd1_req && !prev) begin
                rise_cyc1 = cyc;
                loaded1++;
                check("snd1_pending", exp_q1.size() > 0, 1);
                if (exp_q1.size() > 0) check("snd1_msg", cur, exp_q1.pop_front());
                cap = cur;
            end else if (!snd1_req && prev && reset) begin
                check("snd1_hold", cur, cap);
            end
            prev = snd1_req;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge. Offers one message for up to budget
    // cycles; on ack it records the message in the model and completes the
    // four-phase handshake, otherwise it withdraws the request.
    task automatic send_msg(input int dst, input int dat, input int budget,
                            output bit acked, output int lat, output int t_req);
        msg_t m;
        m = {ASZ'($urandom_range(0, TOP_ADDR)), ASZ'(dst), DSZ'(dat), RSZ'($urandom_range(0, (1 << RSZ) - 1))};
        {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red} = m;
        rcv0_req = 1'b1;
        t_req    = cyc;
        acked    = 1'b0;
        lat      = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge i_clk);
            if (rcv0_ack) begin
                acked = 1'b1;
                lat   = i;
                break;
            end
        end
        if (acked) model_push(m, dst);
        rcv0_req = 1'b0;
        if (acked) begin
            @(negedge i_clk);
            check("rcv0_ack_release", rcv0_ack, 0);
        end
    endtask

    task automatic wait_loaded(input int g, input int target, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge i_clk);
            hit = (g == 0) ? (loaded0 >= target) : (loaded1 >= target);
        end
        check(g == 0 ? "snd0_load_seen" : "snd1_load_seen", hit, 1);
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge i_clk);
            done = (exp_q0.size() == 0) && (exp_q1.size() == 0) &&
                   !snd0_req && !snd1_req && !snd0_ack && !snd1_ack;
        end
        check("drained", done, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit acked;
        int lat, t0, l0b, l1b;

        reset    = 1'b0;
        rcv0_req = 1'b0;
        rcv0_src = '0; rcv0_dst = '0; rcv0_dat = '0; rcv0_red = '0;

        // Reset state
        repeat (3) @(negedge i_clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_rcv0_ack", rcv0_ack, 0);
        check("rst_snd0_req", snd0_req, 0);
        check("rst_snd1_req", snd1_req, 0);
        check("rst_snd0_fields", {snd0_src, snd0_dst, snd0_dat, snd0_red}, 0);
        check("rst_snd1_state", snd1_state, ST_IDLE);

        // Request present at release: the init edge must not take it.
        @(negedge i_clk);
        reset = 1'b1;
        fork
            send_msg(5, 8'hA5, 10, acked, lat, t0);
            begin
                @(negedge i_clk);
                check("ready_after_init", ready, 1);
            end
        join
        check("init_ack_lat", lat, 2);
        wait_loaded(0, 1, 10);
        check("init_snd0_rise_lat", rise_cyc0 - t0, 3);

        // Routing: dst=40 to snd1, dst=5 to snd0, empty-to-output latency 2
        send_msg(40, 8'h3C, 10, acked, lat, t0);
        check("route1_ack_lat", lat, 1);
        wait_loaded(1, 1, 10);
        check("route1_rise_lat", rise_cyc1 - t0, 2);
        wait_drain(50);
        l0b = loaded0;
        send_msg(5, 8'h5A, 10, acked, lat, t0);
        check("route0_ack_lat", lat, 1);
        wait_loaded(0, l0b + 1, 10);
        check("route0_rise_lat", rise_cyc0 - t0, 2);
        wait_drain(50);

        // Backpressure: snd0 stalled. One message sits in the output
        // register, FSZ more fill the FIFO, all acked on the first edge.
        ack_en0 = 1'b0;
        for (int i = 0; i <= FSZ; i++) begin
            send_msg(i + 1, $urandom_range(0, 255), 10, acked, lat, t0);
            check("bp_ack_lat", lat, 1);
        end
        check("bp_snd0_stalled", snd0_req, 1);

        // Head-of-line independence: snd1 traffic passes while snd0 is full.
        l0b = loaded0;
        l1b = loaded1;
        send_msg(50, 8'hC3, 10, acked, lat, t0);
        check("hol_ack_lat", lat, 1);
        wait_loaded(1, l1b + 1, 10);
        check("hol_snd0_still_req", snd0_req, 1);
        check("hol_snd0_no_load", loaded0, l0b);

        // The next snd0-bound message waits until one snd0 handshake ends.
        fork
            send_msg(7, 8'h77, 40, acked, lat, t0);
            begin
                repeat (6) @(negedge i_clk);
                check("bp_held_off", rcv0_ack, 0);
                ack_en0 = 1'b1;
            end
        join
        check("bp_retry_acked", acked, 1);
        check("bp_retry_late", lat > 6, 1);
        wait_drain(100);

        // Wrap-around through snd1: dat 0..9 out in order, none lost
        l1b = loaded1;
        for (int d = 0; d < 10; d++) begin
            send_msg(40 + d, d, 20, acked, lat, t0);
            check("wrap_acked", acked, 1);
        end
        wait_drain(100);
        check("wrap_count", loaded1 - l1b, 10);

        // Randomized traffic with random downstream ack delays
        max_dly = 3;
        for (int n = 0; n < 60; n++) begin
            send_msg($urandom_range(0, TOP_ADDR), $urandom_range(0, 255), 100, acked, lat, t0);
            check("rand_acked", acked, 1);
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
        wait_drain(400);
        max_dly = 0;

        // All-ones destination
        l0b = loaded0;
        l1b = loaded1;
`ifdef NS_ND_1TO2_BROADCAST_EN
        ack_en1 = 1'b0;
        for (int i = 0; i <= FSZ; i++) begin
            send_msg(33 + i, $urandom_range(0, 255), 10, acked, lat, t0);
            check("bc_fill_ack_lat", lat, 1);
        end
        fork
            send_msg(TOP_ADDR, 8'hBC, 40, acked, lat, t0);
            begin
                repeat (6) @(negedge i_clk);
                check("bc_held_off", rcv0_ack, 0);
                ack_en1 = 1'b1;
            end
        join
        check("bc_acked", acked, 1);
        wait_drain(100);
        check("bc_snd0_copy", loaded0 - l0b, 1);
        check("bc_snd1_count", loaded1 - l1b, FSZ + 2);
`else
        send_msg(TOP_ADDR, 8'hBC, 10, acked, lat, t0);
        check("top_addr_ack_lat", lat, 1);
        wait_drain(50);
        check("top_addr_snd1", loaded1 - l1b, 1);
        check("top_addr_snd0", loaded0 - l0b, 0);
`endif

        // Reset mid-transfer: snd0 in REQ with two more queued
        ack_en0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_msg(10 + i, $urandom_range(1, 255), 10, acked, lat, t0);
            check("mid_fill_acked", acked, 1);
        end
        check("mid_snd0_req", snd0_req, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_snd0_req", snd0_req, 0);
        check("mid_rst_snd1_req", snd1_req, 0);
        check("mid_rst_rcv0_ack", rcv0_ack, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_snd0_fields", {snd0_src, snd0_dst, snd0_dat, snd0_red}, 0);
        model_clear();
        repeat (2) @(negedge i_clk);
        reset = 1'b1;
        @(negedge i_clk);
        check("mid_ready_after_init", ready, 1);
        repeat (6) @(negedge i_clk);
        check("mid_idle_snd0", snd0_req, 0);
        check("mid_idle_snd1", snd1_req, 0);
        check("mid_no_loads", loaded0 + loaded1, 0);
        ack_en0 = 1'b1;

        // Node still routes after the mid-operation reset
        send_msg(3, 8'h33, 10, acked, lat, t0);
        check("post_rst_ack_lat", lat, 1);
        wait_drain(50);
        check("post_rst_loaded0", loaded0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
